// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port sync-read memory between fetch and data ports.
// Define ARB_STATS_EN to add saturating conflict and fetch-stall counters.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] MMIO_BASE  = 32'h4000,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    imem_rd_i,
  input  logic [31:0]             imem_addr_i,
  output logic                    imem_gnt_o,
  output logic [DATA_WIDTH-1:0]   inst_o,
  output logic                    inst_valid_o,
  input  logic                    dmem_rd_i,
  input  logic                    dmem_wr_i,
  input  logic [DATA_WIDTH/8-1:0] dmem_strobe_i,
  input  logic [31:0]             dmem_addr_i,
  input  logic [DATA_WIDTH-1:0]   dmem_wdata_i,
  output logic                    dmem_ready_o,
  output logic [DATA_WIDTH-1:0]   dmem_rdata_o,
  output logic                    dmem_rdata_valid_o,
  output logic                    mem_en_o,
  output logic [DATA_WIDTH/8-1:0] mem_strobe_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]             conflict_cnt_o,
  output logic [15:0]             fetch_stall_cnt_o
`endif
);

  localparam logic [3:0] WMAX = 4'(MAX_WAIT);

  typedef enum logic [2:0] {
    T_NONE,
    T_IRD,
    T_DRD,
    T_DMMIO,
    T_IRD_DMMIO
  } tag_e;

  tag_e       tag_q, tag_d;
  logic [3:0] wait_q, wait_d;
  logic       d_req, d_mmio, d_mem;
  logic       d_wr, d_rd;
  logic       force_fetch, f_gnt, d_gnt;
  logic       unused_addr;

  assign unused_addr = ^{imem_addr_i[31:ADDR_WIDTH+2],
                         imem_addr_i[1:0]};

  // Combinational outputs are gated so they read 0 while in reset.
  always_comb begin
    d_req       = rst_ni & (dmem_rd_i | dmem_wr_i);
    d_wr        = dmem_wr_i;
    d_rd        = dmem_rd_i & ~dmem_wr_i;
    d_mmio      = dmem_addr_i >= MMIO_BASE;
    d_mem       = d_req & ~d_mmio;
    force_fetch = imem_rd_i & (wait_q == WMAX);
    f_gnt       = rst_ni & imem_rd_i & (force_fetch | ~d_mem);
    d_gnt       = d_mem & ~f_gnt;
  end

  always_comb begin
    imem_gnt_o   = f_gnt;
    dmem_ready_o = d_gnt | (d_req & d_mmio);
    mem_en_o     = f_gnt | d_gnt;
    mem_strobe_o = '0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    if (f_gnt) begin
      mem_addr_o = imem_addr_i[ADDR_WIDTH+1:2];
    end else if (d_gnt) begin
      mem_addr_o = dmem_addr_i[ADDR_WIDTH+1:2];
      if (d_wr) begin
        mem_strobe_o = dmem_strobe_i;
        mem_wdata_o  = dmem_wdata_i;
      end
    end
  end

  always_comb begin
    tag_d = T_NONE;
    if (f_gnt & d_req & d_mmio & d_rd) begin
      tag_d = T_IRD_DMMIO;
    end else if (f_gnt) begin
      tag_d = T_IRD;
    end else if (d_gnt & d_rd) begin
      tag_d = T_DRD;
    end else if (d_req & d_mmio & d_rd) begin
      tag_d = T_DMMIO;
    end
  end

  always_comb begin
    wait_d = 4'd0;
    if (imem_rd_i & ~f_gnt) begin
      wait_d = (wait_q == WMAX) ? wait_q : wait_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q  <= T_NONE;
      wait_q <= 4'd0;
    end else begin
      tag_q  <= tag_d;
      wait_q <= wait_d;
    end
  end

  always_comb begin
    inst_valid_o       = 1'b0;
    inst_o             = '0;
    dmem_rdata_valid_o = 1'b0;
    dmem_rdata_o       = '0;
    unique case (tag_q)
      T_IRD: begin
        inst_valid_o = 1'b1;
        inst_o       = mem_rdata_i;
      end
      T_DRD: begin
        dmem_rdata_valid_o = 1'b1;
        dmem_rdata_o       = mem_rdata_i;
      end
      T_DMMIO: begin
        dmem_rdata_valid_o = 1'b1;
      end
      T_IRD_DMMIO: begin
        inst_valid_o       = 1'b1;
        inst_o             = mem_rdata_i;
        dmem_rdata_valid_o = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_cnt_o    <= 16'd0;
      fetch_stall_cnt_o <= 16'd0;
    end else begin
      if (imem_rd_i & d_mem & ~&conflict_cnt_o) begin
        conflict_cnt_o <= conflict_cnt_o + 16'd1;
      end
      if (imem_rd_i & ~f_gnt & ~&fetch_stall_cnt_o) begin
        fetch_stall_cnt_o <= fetch_stall_cnt_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with a behavioural
// memory and arbitration reference model.
module tb_mem_port_arbiter;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_rd;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic [31:0] inst;
  logic        inst_valid;
  logic        dmem_rd;
  logic        dmem_wr;
  logic [3:0]  dmem_strobe;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        dmem_rdata_valid;
  logic        mem_en;
  logic [3:0]  mem_strobe;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
`ifdef ARB_STATS_EN
  logic [15:0] conflict_cnt;
  logic [15:0] fetch_stall_cnt;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH(12),
    .MAX_WAIT(MAXW)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .imem_rd_i(imem_rd),
    .imem_addr_i(imem_addr),
    .imem_gnt_o(imem_gnt),
    .inst_o(inst),
    .inst_valid_o(inst_valid),
    .dmem_rd_i(dmem_rd),
    .dmem_wr_i(dmem_wr),
    .dmem_strobe_i(dmem_strobe),
    .dmem_addr_i(dmem_addr),
    .dmem_wdata_i(dmem_wdata),
    .dmem_ready_o(dmem_ready),
    .dmem_rdata_o(dmem_rdata),
    .dmem_rdata_valid_o(dmem_rdata_valid),
    .mem_en_o(mem_en),
    .mem_strobe_o(mem_strobe),
    .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
`ifdef ARB_STATS_EN
    ,
    .conflict_cnt_o(conflict_cnt),
    .fetch_stall_cnt_o(fetch_stall_cnt)
`endif
  );

  function automatic logic [31:0] init_val(input int i);
    if (i == 2) return 32'h0;
    if (i == 4) return 32'h0000_0013;
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  // Memory behind the arbiter, driven only by the DUT's mem_* outputs.
  logic [31:0] ram [4096];
  logic        loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 4096; i++) ram[i] <= init_val(i);
      loaded <= 1'b1;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_strobe[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= ram[mem_addr];
    end else begin
      mem_rdata <= $urandom;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;
  exp_t iq[$];
  exp_t dq[$];

  logic [31:0] ref_mem [4096];
  int          denied = 0;
  int          conf_m = 0;
  int          stall_m = 0;

  logic        s_ir, s_drd, s_dwr;
  logic [31:0] s_ia, s_da, s_wd;
  logic [3:0]  s_st;
  logic        ex_fg, ex_dr;

  task automatic set(input logic ir, input logic [31:0] ia,
                     input logic rd, input logic wr, input logic [3:0] st,
                     input logic [31:0] da, input logic [31:0] wd);
    s_ir = ir; s_ia = ia; s_drd = rd; s_dwr = wr;
    s_st = st; s_da = da; s_wd = wd;
  endtask

  task automatic drive();
    imem_rd = s_ir; imem_addr = s_ia;
    dmem_rd = s_drd; dmem_wr = s_dwr; dmem_strobe = s_st;
    dmem_addr = s_da; dmem_wdata = s_wd;
  endtask

  // One modelled cycle: drive after the edge, check and predict mid-cycle.
  task automatic step();
    logic        dreq, mmio, need, fw, dw, rd;
    logic [31:0] ea;
    exp_t        e;
    @(posedge clk); #1;
`ifdef ARB_STATS_EN
    chk("conflict_cnt", 32'(conflict_cnt), conf_m);
    chk("stall_cnt", 32'(fetch_stall_cnt), stall_m);
`endif
    drive();
    @(negedge clk);
    dreq = s_drd | s_dwr;
    mmio = s_da >= 32'h4000;
    need = dreq && !mmio;
    fw   = s_ir && (!need || denied >= MAXW);
    dw   = need && !fw;
    rd   = s_drd && !s_dwr;
    ea   = fw ? 32'(s_ia[13:2]) : dw ? 32'(s_da[13:2]) : 32'h0;
    chk("imem_gnt", 32'(imem_gnt), 32'(fw));
    chk("dmem_ready", 32'(dmem_ready), 32'(dreq && (mmio || dw)));
    chk("mem_en", 32'(mem_en), 32'(fw || dw));
    chk("mem_addr", 32'(mem_addr), ea);
    chk("mem_strobe", 32'(mem_strobe), (dw && s_dwr) ? 32'(s_st) : 32'h0);
    chk("mem_wdata", mem_wdata, (dw && s_dwr) ? s_wd : 32'h0);
    e.due = cyc + 1;
    if (fw) begin
      e.data = ref_mem[s_ia[13:2]];
      iq.push_back(e);
    end
    if (dw && rd) begin
      e.data = ref_mem[s_da[13:2]];
      dq.push_back(e);
    end
    if (dreq && mmio && rd) begin
      e.data = 32'h0;
      dq.push_back(e);
    end
    if (dw && s_dwr)
      for (int b = 0; b < 4; b++)
        if (s_st[b]) ref_mem[s_da[13:2]][8*b +: 8] = s_wd[8*b +: 8];
    if (s_ir && need && conf_m < 65535) conf_m++;
    if (s_ir && !fw && stall_m < 65535) stall_m++;
    denied = (s_ir && !fw) ? ((denied < MAXW) ? denied + 1 : MAXW) : 0;
    ex_fg = fw;
    ex_dr = dreq && (mmio || dw);
  endtask

  // Monitor: pops the scoreboard whenever a response is presented.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (inst_valid) begin
          if (iq.size() == 0) chk("inst_spurious", 32'h1, 32'h0);
          else begin
            e = iq.pop_front();
            chk("inst_cycle", cyc, e.due);
            chk("inst_data", inst, e.data);
          end
        end else begin
          chk("inst_idle", inst, 32'h0);
          if (iq.size() > 0 && iq[0].due == cyc) begin
            chk("inst_missing", 32'h0, 32'h1);
            void'(iq.pop_front());
          end
        end
        if (dmem_rdata_valid) begin
          if (dq.size() == 0) chk("drd_spurious", 32'h1, 32'h0);
          else begin
            e = dq.pop_front();
            chk("drd_cycle", cyc, e.due);
            chk("drd_data", dmem_rdata, e.data);
          end
        end else begin
          chk("drd_idle", dmem_rdata, 32'h0);
          if (dq.size() > 0 && dq[0].due == cyc) begin
            chk("drd_missing", 32'h0, 32'h1);
            void'(dq.pop_front());
          end
        end
      end
    end
  end

  function automatic logic [31:0] rand_daddr();
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 31)) << 2;
      1: return 32'h3FF0 + 32'($urandom_range(0, 15));
      2: return 32'h4000 + 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic        f_pend, d_pend, d_rd, d_wr;
    logic [31:0] f_a, d_a, d_wd;
    logic [3:0]  d_st;
    int          k;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);

    set(1'b1, 32'h10, 1'b1, 1'b0, 4'h0, 32'h4000, 32'h0);
    drive();
    #12;
    chk("rst_imem_gnt", 32'(imem_gnt), 32'h0);
    chk("rst_dmem_ready", 32'(dmem_ready), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_inst_valid", 32'(inst_valid), 32'h0);
    chk("rst_drd_valid", 32'(dmem_rdata_valid), 32'h0);
    set(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive();
    @(negedge clk); #2;
    rst_n = 1'b1;
    #1;
    chk("post_rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("post_rst_inst", inst, 32'h0);

    set(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); step();
    set(1'b0, 32'h0, 1'b0, 1'b1, 4'b0011, 32'h8, 32'hAABB_CCDD); step();
    set(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0); step();
    for (int i = 0; i < 6; i++) begin
      set(1'b1, 32'h20, 1'b1, 1'b0, 4'h0, 32'h30, 32'h0); step();
    end
    set(1'b1, 32'h40, 1'b1, 1'b0, 4'h0, 32'h4004, 32'h0); step();
    set(1'b0, 32'h0, 1'b0, 1'b1, 4'hF, 32'h5000, 32'h1234_5678); step();
    set(1'b0, 32'h0, 1'b0, 1'b1, 4'hF, 32'h4000, 32'hDEAD_BEEF); step();
    set(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h3FFC, 32'h0); step();
    set(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h3FFC, 32'h0BAD_F00D); step();
    set(1'b1, 32'h3FFC, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); step();
    set(1'b0, 32'h0, 1'b0, 1'b1, 4'h0, 32'h8, 32'hFFFF_FFFF); step();
    set(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0); step();
    set(1'b1, 32'h0, 1'b1, 1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0); step();

    f_pend = 1'b0; d_pend = 1'b0; f_a = 0; d_a = 0;
    d_rd = 0; d_wr = 0; d_st = 0; d_wd = 0;
    for (int n = 0; n < 2500; n++) begin
      if (!f_pend && $urandom_range(0, 9) < 6) begin
        f_pend = 1'b1;
        f_a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 127))
                                           : 32'h3F00 + 32'($urandom_range(0, 255));
      end
      if (!d_pend && $urandom_range(0, 9) < 6) begin
        d_pend = 1'b1;
        d_a = rand_daddr();
        d_wd = $urandom;
        d_st = 4'($urandom);
        k = $urandom_range(0, 5);
        d_rd = (k <= 1) || (k == 4);
        d_wr = (k >= 2);
        if (k == 5) d_st = 4'h0;
      end
      set(f_pend, f_pend ? f_a : $urandom,
          d_pend && d_rd, d_pend && d_wr,
          d_pend ? d_st : 4'($urandom),
          d_pend ? d_a : $urandom, d_pend ? d_wd : $urandom);
      step();
      if (ex_fg) f_pend = 1'b0;
      if (ex_dr) d_pend = 1'b0;
    end

    set(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0); step();
    @(posedge clk); #1;
    set(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive();
    chk("pre_rst_drd_valid", 32'(dmem_rdata_valid), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_drd_valid", 32'(dmem_rdata_valid), 32'h0);
    iq.delete(); dq.delete();
    denied = 0; conf_m = 0; stall_m = 0;
    @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_quiet", 32'(dmem_rdata_valid), 32'h0);
    end
    set(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h3FFC, 32'h0); step();
    set(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); step();
    step();
    #1;
    chk("iq_drained", 32'(iq.size()), 32'h0);
    chk("dq_drained", 32'(dq.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port synchronous-read memory between the core's instruction-fetch port and its data port. It generates the core's imem grant, dmem ready and dmem read-valid handshakes. A starvation counter guarantees fetch progress under sustained data traffic. Data addresses at or above MMIO_BASE are intercepted: they never touch the memory, and reads from them return zero.

Parameters:
ADDR_WIDTH, 12, memory word-address width
DATA_WIDTH, 32, data word width (fixed 32; strobe is DATA_WIDTH/8 bits)
MMIO_BASE, 32'h4000, first byte address excluded from memory
MAX_WAIT, 4, consecutive denied fetch cycles before fetch is forced to win (1..15)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
imem_rd_i  in  1  fetch request
imem_addr_i  in  32  fetch byte address
imem_gnt_o  out  1  fetch accepted this cycle
inst_o  out  32  fetched instruction
inst_valid_o  out  1  inst_o valid (one cycle after grant)
dmem_rd_i  in  1  data read request
dmem_wr_i  in  1  data write request
dmem_strobe_i  in  4  byte write enables
dmem_addr_i  in  32  data byte address
dmem_wdata_i  in  32  write data
dmem_ready_o  out  1  data request accepted this cycle
dmem_rdata_o  out  32  read data
dmem_rdata_valid_o  out  1  dmem_rdata_o valid (one cycle after accepted read)
mem_en_o  out  1  memory enable
mem_strobe_o  out  4  memory byte write enables
mem_addr_o  out  ADDR_WIDTH  memory word address
mem_wdata_o  out  32  memory write data
mem_rdata_i  in  32  memory read data (valid cycle after mem_en_o with strobe 0)

Behaviour:
- Reset is asynchronous and active-low on rst_ni; clock is clk_i. While reset is asserted, all outputs are 0, the wait counter is 0, and the response tag is NONE.
- Combinational decision each cycle:
  - d_req = dmem_rd_i | dmem_wr_i.
  - d_mmio = dmem_addr_i >= MMIO_BASE (unsigned 32-bit compare).
  - force_i = imem_rd_i & (wait_cnt == MAX_WAIT).
- Priority:
  - If force_i, fetch wins.
  - Otherwise a data request wins over fetch.
  - A lone requester always wins.
- MMIO data access needs no memory cycle and is accepted in the same cycle even when fetch wins the memory: dmem_ready_o=1, no memory access.
  - MMIO write is discarded.
  - MMIO read returns 0 next cycle with dmem_rdata_valid_o=1.
- Memory-granted access:
  - mem_en_o=1.
  - mem_addr_o = addr[ADDR_WIDTH+1:2].
  - Data write: mem_strobe_o = dmem_strobe_i, mem_wdata_o = dmem_wdata_i.
  - Fetch: mem_strobe_o = 0.
- Simultaneous dmem_rd_i and dmem_wr_i: treated as a write only; no read-valid is produced.
- Write with strobe 0: accepted; behaves as a memory read cycle with no read-valid.
- Idle cycle: mem_en_o=0, mem_strobe_o=0, mem_addr_o and mem_wdata_o hold 0.
- Response tag register (states NONE, IRD, DRD, DMMIO) is loaded each cycle from the accepted transaction:
  - IRD: inst_valid_o=1, inst_o=mem_rdata_i.
  - DRD: dmem_rdata_valid_o=1, dmem_rdata_o=mem_rdata_i.
  - DMMIO: dmem_rdata_valid_o=1, dmem_rdata_o=0.
  - Fetch and an MMIO read accepted in the same cycle both respond next cycle.
  - Non-valid data outputs drive 0.
- Read latency is exactly 1 cycle. Back-to-back accepts are allowed every cycle. Requesters hold the request until the grant and capture data in the valid cycle; nothing is buffered.
- wait_cnt (4 bits):
  - Increments when imem_rd_i=1 and the fetch is not granted.
  - Clears on a fetch grant or when imem_rd_i=0.
  - Never exceeds MAX_WAIT.
- Reset mid-operation: the pending response is dropped; no valid is issued after reset release until a new accept.

Optional Feature:
ARB_STATS_EN
- Defined: adds outputs conflict_cnt_o (16-bit) and fetch_stall_cnt_o (16-bit), both saturating at 16'hFFFF and reset to 0.
  - conflict_cnt_o increments in each cycle where fetch and a non-MMIO data request are both present.
  - fetch_stall_cnt_o increments in each cycle where imem_rd_i=1 and imem_gnt_o=0.
- Undefined: the ports and counters do not exist; arbitration behaviour is identical.

Test Plan:
1. Reset, then fetch-only read of 0x0000_0010 with memory word 4 = 32'h0000_0013 -> mem_addr_o=4 and imem_gnt_o=1 in the same cycle; next cycle inst_valid_o=1, inst_o=32'h0000_0013.
2. Data write to 0x0000_0008 with strobe 4'b0011 and data 32'hAABB_CCDD, then read of the same address (memory word initially 0) -> dmem_rdata_o=32'h0000_CCDD one cycle after the read accept.
3. Fetch and data reads held for 6 cycles with MAX_WAIT=4 -> data granted in cycles 0..3, fetch granted in cycle 4, wait_cnt returns to 0, data granted in cycle 5.
4. Fetch plus data read at 0x0000_4004 in the same cycle -> both grants=1, mem_addr_o=fetch word; next cycle inst_valid_o=1 and dmem_rdata_valid_o=1 with dmem_rdata_o=0. MMIO write to 0x0000_5000 -> mem_en_o=0 and memory unchanged.
5. rst_ni pulsed low asynchronously in the cycle after a data read accept -> dmem_rdata_valid_o=0 immediately and stays 0 after release until a new request.
6. With ARB_STATS_EN, 3 conflict cycles -> conflict_cnt_o=3 and fetch_stall_cnt_o=3; a forced 16'hFFFF preload stays at 16'hFFFF after a further conflict.
